// File: rtl/blackboxed_regfile_pkg.sv
// Shared types and the byte-lane merge rule for the multi-port register file.
package regfile_pkg;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

   localparam int LANE_W = 8;

   // An invalid entry contributes zero to lanes that are not being written.
   function automatic logic [LANE_W-1:0] lane_merge(input logic [LANE_W-1:0] old_lane,
                                                   input logic [LANE_W-1:0] new_lane,
                                                   input logic              mask,
                                                   input logic              valid);
      if (mask) return new_lane;
      if (valid) return old_lane;
      return '0;
   endfunction

endpackage

// File: rtl/blackboxed_regfile_if.sv
// Write, read and clear signals of the register file, grouped for port passing.
interface blackboxed_regfile_if #(
   parameter int WIDTH    = 64,
   parameter int IDXWIDTH = 5,
   parameter int NREAD    = 2
);
   logic                      w_en;
   logic                      w_ready;
   logic [IDXWIDTH-1:0]       w_idx;
   logic [WIDTH-1:0]          w_data;
   logic [WIDTH/8-1:0]        w_mask;
   logic [NREAD*IDXWIDTH-1:0] r_idx;
   logic [NREAD*WIDTH-1:0]    r_data;
   logic [NREAD-1:0]          r_valid;
   logic                      clr_req;
   logic                      clr_busy;
   logic                      clr_done;

   modport master (
      output w_en, w_idx, w_data, w_mask, r_idx, clr_req,
      input  w_ready, r_data, r_valid, clr_busy, clr_done
   );

   modport slave (
      input  w_en, w_idx, w_data, w_mask, r_idx, clr_req,
      output w_ready, r_data, r_valid, clr_busy, clr_done
   );
endinterface

// File: rtl/blackboxed_regfile_clear_fsm.sv
// Sequential clear engine: walks the array one entry per cycle, then pulses done.
//   state | meaning
//   IDLE  | waiting for clr_req
//   CLEAR | zeroing entry ptr this cycle, ptr advances
//   DONE  | one-cycle clr_done pulse, back to IDLE
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int NREGS    = 32,
   parameter int IDXWIDTH = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr_req,
   output logic                clr_busy,
   output logic                clr_done,
   output logic                clr_wr,
   output logic [IDXWIDTH-1:0] clr_idx
);

   localparam logic [IDXWIDTH-1:0] LAST = IDXWIDTH'(NREGS - 1);

   clr_state_t          state, state_nx;
   logic [IDXWIDTH-1:0] ptr, ptr_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      clr_busy = 1'b0;
      clr_done = 1'b0;
      clr_wr   = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nx = CLEAR;
               ptr_nx   = '0;
            end
         end
         CLEAR: begin
            clr_busy = 1'b1;
            clr_wr   = 1'b1;
            ptr_nx   = ptr + IDXWIDTH'(1);
            if (ptr == LAST) state_nx = DONE;
         end
         DONE: begin
            clr_done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign clr_idx = ptr;

endmodule

// File: rtl/blackboxed_regfile.sv
// Multi-read-port register file with byte-masked writes, valid bits, optional
// write-to-read bypass and a one-entry-per-cycle clear engine.
module blackboxed_regfile
   import regfile_pkg::*;
#(
   parameter int NREGS    = 32,
   parameter int WIDTH    = 64,
   parameter int IDXWIDTH = 5,
   parameter int NREAD    = 2,
   parameter int BYPASS   = 0
) (
   input logic                  clk,
   input logic                  reset,
   blackboxed_regfile_if.slave  bus
);

   localparam int                NLANES  = WIDTH / 8;
   localparam logic [IDXWIDTH:0] NREGS_X = (IDXWIDTH + 1)'(NREGS);

   logic [WIDTH-1:0]    mem [NREGS];
   logic [NREGS-1:0]    valid;

   logic                clr_busy, clr_done, clr_wr;
   logic [IDXWIDTH-1:0] clr_idx;

   logic                w_in, w_acc, w_old_valid;
   logic [WIDTH-1:0]    w_old, w_merged;

   regfile_clear_fsm #(.NREGS(NREGS), .IDXWIDTH(IDXWIDTH)) u_clear (
      .clk      (clk),
      .reset    (reset),
      .clr_req  (bus.clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_wr   (clr_wr),
      .clr_idx  (clr_idx)
   );

   assign bus.w_ready  = !clr_busy;
   assign bus.clr_busy = clr_busy;
   assign bus.clr_done = clr_done;

   // Out-of-range writes still handshake but never touch the array.
   assign w_in        = {1'b0, bus.w_idx} < NREGS_X;
   assign w_acc       = bus.w_en && !clr_busy && w_in;
   assign w_old_valid = w_in ? valid[bus.w_idx] : 1'b0;
   assign w_old       = w_in ? mem[bus.w_idx] : '0;

   for (genvar k = 0; k < NLANES; k++) begin : g_lane
      assign w_merged[8*k +: 8] = lane_merge(w_old[8*k +: 8], bus.w_data[8*k +: 8],
                                             bus.w_mask[k], w_old_valid);
   end

   // Data storage has no reset; valid bits gate every read.
   always_ff @(posedge clk) begin
      if (clr_wr)     mem[clr_idx]   <= '0;
      else if (w_acc) mem[bus.w_idx] <= w_merged;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      valid          <= '0;
      else if (clr_wr) valid[clr_idx] <= 1'b0;
      else if (w_acc) valid[bus.w_idx] <= 1'b1;
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [IDXWIDTH-1:0] idx;
      logic                in_rng, hit, rv;
      logic [WIDTH-1:0]    rd;

      assign idx    = bus.r_idx[p*IDXWIDTH +: IDXWIDTH];
      assign in_rng = {1'b0, idx} < NREGS_X;
      assign hit    = (BYPASS != 0) && w_acc && (bus.w_idx == idx);

      always_comb begin
         rv = 1'b0;
         rd = '0;
         if (hit) begin
            rv = 1'b1;
            rd = w_merged;
         end else if (in_rng && valid[idx]) begin
            rv = 1'b1;
            rd = mem[idx];
         end
      end

      assign bus.r_valid[p]              = rv;
      assign bus.r_data[p*WIDTH +: WIDTH] = rd;
   end

endmodule

// File: tb/tb_blackboxed_regfile.sv
// Bench: two instances (32 entries no bypass, 24 entries with bypass) share stimulus
// and are checked every cycle against an array-based model of the register file.
module tb_blackboxed_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        w_en = 1'b0;
   logic [4:0]  w_idx = '0;
   logic [63:0] w_data = '0;
   logic [7:0]  w_mask = '0;
   logic [4:0]  r_idx0 = '0, r_idx1 = '0;
   logic        clr_req = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   blackboxed_regfile_if #(.WIDTH(64), .IDXWIDTH(5), .NREAD(2)) i0 ();
   blackboxed_regfile_if #(.WIDTH(64), .IDXWIDTH(5), .NREAD(2)) i1 ();

   assign i0.w_en = w_en;   assign i1.w_en = w_en;
   assign i0.w_idx = w_idx; assign i1.w_idx = w_idx;
   assign i0.w_data = w_data; assign i1.w_data = w_data;
   assign i0.w_mask = w_mask; assign i1.w_mask = w_mask;
   assign i0.r_idx = {r_idx1, r_idx0}; assign i1.r_idx = {r_idx1, r_idx0};
   assign i0.clr_req = clr_req; assign i1.clr_req = clr_req;

   blackboxed_regfile #(.NREGS(32), .WIDTH(64), .IDXWIDTH(5), .NREAD(2), .BYPASS(0))
      dut0 (.clk(clk), .reset(rst), .bus(i0));
   blackboxed_regfile #(.NREGS(24), .WIDTH(64), .IDXWIDTH(5), .NREAD(2), .BYPASS(1))
      dut1 (.clk(clk), .reset(rst), .bus(i1));

   logic [1:0]   d_ready, d_busy, d_done;
   logic [127:0] d_rdata [2];
   logic [1:0]   d_rvalid [2];
   assign d_ready[0] = i0.w_ready;  assign d_ready[1] = i1.w_ready;
   assign d_busy[0]  = i0.clr_busy; assign d_busy[1]  = i1.clr_busy;
   assign d_done[0]  = i0.clr_done; assign d_done[1]  = i1.clr_done;
   assign d_rdata[0] = i0.r_data;   assign d_rdata[1] = i1.r_data;
   assign d_rvalid[0] = i0.r_valid; assign d_rvalid[1] = i1.r_valid;

   // ---------------- reference model ----------------
   int          nregs [2] = '{32, 24};
   bit          byp   [2] = '{1'b0, 1'b1};
   logic [63:0] md [2][32];
   bit          mv [2][32];
   int          ph [2];   // -1 idle, 0..n-1 clear cycle number, n = done cycle

   function automatic bit m_busy(int d);
      return ph[d] >= 0 && ph[d] < nregs[d];
   endfunction

   function automatic bit m_acc(int d);
      return w_en && !m_busy(d) && (int'(w_idx) < nregs[d]);
   endfunction

   function automatic logic [63:0] m_merge(int d);
      logic [63:0] r;
      logic [63:0] old;
      old = (int'(w_idx) < nregs[d] && mv[d][w_idx]) ? md[d][w_idx] : 64'h0;
      for (int k = 0; k < 8; k++)
         r[8*k +: 8] = w_mask[k] ? w_data[8*k +: 8] : old[8*k +: 8];
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            for (int i = 0; i < 32; i++) mv[d][i] <= 1'b0;
            ph[d] <= -1;
         end else begin
            if (m_acc(d)) begin
               md[d][w_idx] <= m_merge(d);
               mv[d][w_idx] <= 1'b1;
            end
            if (m_busy(d)) begin
               md[d][ph[d]] <= 64'h0;
               mv[d][ph[d]] <= 1'b0;
               ph[d] <= ph[d] + 1;
            end else if (ph[d] == nregs[d]) ph[d] <= -1;
            else if (ph[d] == -1 && clr_req) ph[d] <= 0;
         end
      end
   end

   task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int d = 0; d < 2; d++) begin
            logic [4:0]  ri;
            logic [63:0] ed;
            bit          ev;
            ck($sformatf("busy%0d", d), 64'(d_busy[d]), 64'(m_busy(d)));
            ck($sformatf("ready%0d", d), 64'(d_ready[d]), 64'(!m_busy(d)));
            ck($sformatf("done%0d", d), 64'(d_done[d]), 64'(ph[d] == nregs[d]));
            for (int p = 0; p < 2; p++) begin
               ri = (p == 0) ? r_idx0 : r_idx1;
               if (byp[d] && m_acc(d) && ri == w_idx) begin
                  ed = m_merge(d); ev = 1'b1;
               end else if (int'(ri) < nregs[d] && mv[d][ri]) begin
                  ed = md[d][ri]; ev = 1'b1;
               end else begin
                  ed = 64'h0; ev = 1'b0;
               end
               ck($sformatf("rdata%0d_p%0d", d, p), d_rdata[d][p*64 +: 64], ed);
               ck($sformatf("rvalid%0d_p%0d", d, p), 64'(d_rvalid[d][p]), 64'(ev));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [63:0] data, input logic [7:0] mask);
      w_en = 1'b1; w_idx = idx; w_data = data; w_mask = mask;
      tick();
      w_en = 1'b0;
   endtask

   int busy_cnt [2];
   int done_cnt [2];

   initial begin
      tick(); tick();
      // reset state
      r_idx0 = 5'd0; r_idx1 = 5'd31; #1;
      ck("rst_rvalid", 64'(d_rvalid[0]), 64'h0);
      ck("rst_rdata", d_rdata[0][127:64] | d_rdata[0][63:0], 64'h0);
      ck("rst_ready", 64'(d_ready[0]), 64'h1);
      ck("rst_busy", 64'(d_busy[0]), 64'h0);
      rst = 1'b0;
      chk_en = 1'b1;
      tick();

      wr(5'd3, 64'h1122334455667788, 8'hFF);
      r_idx0 = 5'd3; r_idx1 = 5'd3; #1;
      ck("full_wr_p0", d_rdata[0][63:0], 64'h1122334455667788);
      ck("full_wr_p1", d_rdata[0][127:64], 64'h1122334455667788);
      ck("full_wr_v", 64'(d_rvalid[0]), 64'h3);

      wr(5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      #1;
      ck("part_wr", d_rdata[0][63:0], 64'h11223344AAAAAAAA);

      wr(5'd7, 64'hFFFFFFFFFFFFFFFF, 8'h01);
      r_idx0 = 5'd7; #1;
      ck("part_inv", d_rdata[0][63:0], 64'h00000000000000FF);
      ck("part_inv_v", 64'(d_rvalid[0][0]), 64'h1);

      // bypass: same-cycle read of a write being accepted
      r_idx0 = 5'd5;
      w_en = 1'b1; w_idx = 5'd5; w_data = 64'hDEAD; w_mask = 8'hFF; #1;
      ck("byp1_data", d_rdata[1][63:0], 64'hDEAD);
      ck("byp1_v", 64'(d_rvalid[1][0]), 64'h1);
      ck("byp0_data", d_rdata[0][63:0], 64'h0);
      ck("byp0_v", 64'(d_rvalid[0][0]), 64'h0);
      tick(); w_en = 1'b0; #1;
      ck("byp0_next", d_rdata[0][63:0], 64'hDEAD);

      // index 30 is beyond the 24-entry instance
      wr(5'd30, 64'h0123, 8'hFF);
      r_idx0 = 5'd30; #1;
      ck("oor_v24", 64'(d_rvalid[1][0]), 64'h0);
      ck("oor_d24", d_rdata[1][63:0], 64'h0);
      ck("oor_v32", 64'(d_rvalid[0][0]), 64'h1);

      // fill and clear, with a write attempted mid-clear
      for (int i = 0; i < 32; i++) wr(5'(i), {32'(i), $urandom}, 8'hFF);
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      busy_cnt = '{0, 0}; done_cnt = '{0, 0};
      for (int c = 0; c < 100; c++) begin
         #1;
         for (int d = 0; d < 2; d++) begin
            if (d_busy[d]) begin
               busy_cnt[d]++;
               ck($sformatf("clr_ready%0d", d), 64'(d_ready[d]), 64'h0);
            end
            if (d_done[d]) done_cnt[d]++;
         end
         if (busy_cnt[0] == 5) begin
            w_en = 1'b1; w_idx = 5'd0; w_data = '1; w_mask = 8'hFF;
         end else w_en = 1'b0;
         if (done_cnt[0] != 0) break;
         tick();
         if (c == 99) ck("clr_timeout", 64'(c), 64'(0));
      end
      w_en = 1'b0;
      tick(); tick(); #1;
      for (int d = 0; d < 2; d++)
         if (d_done[d]) done_cnt[d]++;
      ck("busy_len32", 64'(busy_cnt[0]), 64'd32);
      ck("busy_len24", 64'(busy_cnt[1]), 64'd24);
      ck("done_once0", 64'(done_cnt[0]), 64'd1);
      ck("done_once1", 64'(done_cnt[1]), 64'd1);
      for (int i = 0; i < 32; i += 2) begin
         r_idx0 = 5'(i); r_idx1 = 5'(i + 1); #1;
         ck($sformatf("post_clr_v%0d", i), 64'(d_rvalid[0]), 64'h0);
      end

      // reset in the middle of a clear
      for (int i = 0; i < 32; i++) wr(5'(i), 64'(i + 1), 8'hFF);
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      for (int c = 0; c < 9; c++) tick();
      r_idx0 = 5'd20; #1;
      ck("pre_rst_v", 64'(d_rvalid[0][0]), 64'h1);
      chk_en = 1'b0;
      rst = 1'b1; #1;
      ck("mid_rst_busy", 64'(d_busy), 64'h0);
      ck("mid_rst_ready", 64'(d_ready), 64'h3);
      ck("mid_rst_done", 64'(d_done), 64'h0);
      ck("mid_rst_rv", 64'(d_rvalid[0]), 64'h0);
      ck("mid_rst_rd", d_rdata[0][63:0], 64'h0);
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;
      tick();
      for (int i = 10; i < 32; i++) begin
         r_idx0 = 5'(i); #1;
         ck($sformatf("after_rst_v%0d", i), 64'(d_rvalid[0][0]), 64'h0);
      end

      // randomized traffic, checked by the per-cycle compare
      for (int c = 0; c < 600; c++) begin
         w_en    = 1'($urandom_range(0, 1));
         w_idx   = 5'($urandom_range(0, 31));
         w_data  = {$urandom, $urandom};
         w_mask  = 8'($urandom);
         r_idx0  = ($urandom_range(0, 1) == 1) ? w_idx : 5'($urandom_range(0, 31));
         r_idx1  = 5'($urandom_range(0, 31));
         clr_req = ($urandom_range(0, 59) == 0);
         tick();
      end
      w_en = 1'b0; clr_req = 1'b0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
